// File: rtl/pet_battle_engine.sv
// pet_battle_engine
//   Generates a roster of PETS pets per player from an RNG word, runs per-player
//   pet selection from keyboard codes, then turn-based combat with damage,
//   faint handling, forced reselection and winner detection.
//
// Ports
//   clk        clock
//   reset      synchronous, active-low reset
//   rand_in    RNG word {ATK, DEF, HP}, sampled once per pet during generation
//   key_valid  one-cycle strobe qualifying key_code
//   key_code   decoded key from keyboard_tracker
//   rd_player  roster read port: player (0 = P1, 1 = P2)
//   rd_idx     roster read port: pet index
//   rd_stats   combinational {ATK, DEF, HP} of the addressed pet
//   state      FSM state encoding
//   p1_sel     active pet index of P1
//   p2_sel     active pet index of P2
//   turn       0 = P1 attacks next, 1 = P2 attacks next
//   sel_err    one-cycle pulse when a fainted pet was selected
//   winner     00 none, 01 P1, 10 P2
//   game_over  high in OVER
//
// state  | meaning
// IDLE   | waiting for GEN_KEY
// GEN    | writing one pet per cycle, P1 pets then P2 pets
// SEL1   | P1 picks a pet (initially, or after its active pet fainted)
// SEL2   | P2 picks a pet (initially, or after its active pet fainted)
// FIGHT  | ATTACK_KEY resolves one attack by the turn player
// OVER   | winner latched, GEN_KEY restarts
module pet_battle_engine #(
    parameter int PETS       = 4,
    parameter int STAT_W     = 3,
    parameter int KEY_W      = 5,
    parameter int ATTACK_KEY = 10,
    parameter int GEN_KEY    = 14,
    localparam int IDX_W     = (PETS > 1) ? $clog2(PETS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3*STAT_W-1:0]   rand_in,
    input  logic                  key_valid,
    input  logic [KEY_W-1:0]      key_code,
    input  logic                  rd_player,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [3*STAT_W-1:0]   rd_stats,
    output logic [2:0]            state,
    output logic [IDX_W-1:0]      p1_sel,
    output logic [IDX_W-1:0]      p2_sel,
    output logic                  turn,
    output logic                  sel_err,
    output logic [1:0]            winner,
    output logic                  game_over
);

    // Roster is flat: P1 pets at 0..PETS-1, P2 pets at PETS..2*PETS-1,
    // so the generation counter doubles as the write address.
    localparam int AW = $clog2(2 * PETS);
    localparam logic [AW-1:0]    G_LAST   = AW'(2 * PETS - 1);
    localparam logic [AW-1:0]    P2_BASE  = AW'(PETS);
    localparam logic [KEY_W-1:0] K_ATTACK = KEY_W'(ATTACK_KEY);
    localparam logic [KEY_W-1:0] K_GEN    = KEY_W'(GEN_KEY);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN   = 3'd1,
        SEL1  = 3'd2,
        SEL2  = 3'd3,
        FIGHT = 3'd4,
        OVER  = 3'd5
    } state_t;

    state_t state_q, state_next;

    logic [STAT_W-1:0] hp  [2*PETS];
    logic [STAT_W-1:0] def [2*PETS];
    logic [STAT_W-1:0] atk [2*PETS];

    logic [AW-1:0] g;
    logic          reselect;

    logic          gen_start, gen_wr, sel1_ok, sel2_ok, sel_fail, attack;
    logic          hit1, hit2, others_alive;
    logic [IDX_W-1:0] k1_idx, k2_idx;
    logic [AW-1:0] s1_ix, s2_ix, a_ix, d_ix, rd_ix, o_ix;
    logic [STAT_W-1:0] dmg, hp_new;

    function automatic logic [STAT_W-1:0] clamp1(input logic [STAT_W-1:0] v);
        return (v == '0) ? STAT_W'(1) : v;
    endfunction

    always_comb begin
        rd_ix = rd_player ? (P2_BASE + AW'(rd_idx)) : AW'(rd_idx);
        rd_stats = '0;
        if (int'(rd_idx) < PETS)
            rd_stats = {atk[rd_ix], def[rd_ix], hp[rd_ix]};
    end

    // Key decode and attack arithmetic
    always_comb begin
        hit1   = (key_code >= KEY_W'(1)) && (key_code <= KEY_W'(PETS));
        hit2   = (key_code >= KEY_W'(PETS + 1)) && (key_code <= KEY_W'(2 * PETS));
        k1_idx = IDX_W'(key_code - KEY_W'(1));
        k2_idx = IDX_W'(key_code - KEY_W'(PETS + 1));
        s1_ix  = AW'(k1_idx);
        s2_ix  = P2_BASE + AW'(k2_idx);

        a_ix = turn ? (P2_BASE + AW'(p2_sel)) : AW'(p1_sel);
        d_ix = turn ? AW'(p1_sel) : (P2_BASE + AW'(p2_sel));

        dmg    = (atk[a_ix] > def[d_ix]) ? (atk[a_ix] - def[d_ix]) : STAT_W'(1);
        hp_new = (hp[d_ix] > dmg) ? (hp[d_ix] - dmg) : '0;

        others_alive = 1'b0;
        o_ix = '0;
        for (int i = 0; i < PETS; i++) begin
            o_ix = AW'(i) + (turn ? '0 : P2_BASE);
            if (o_ix != d_ix && hp[o_ix] != '0)
                others_alive = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        gen_start  = 1'b0;
        gen_wr     = 1'b0;
        sel1_ok    = 1'b0;
        sel2_ok    = 1'b0;
        sel_fail   = 1'b0;
        attack     = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid && key_code == K_GEN) begin
                    gen_start  = 1'b1;
                    state_next = GEN;
                end
            end
            GEN: begin
                gen_wr = 1'b1;
                if (g == G_LAST) state_next = SEL1;
            end
            SEL1: begin
                if (key_valid && hit1) begin
                    if (hp[s1_ix] != '0) begin
                        sel1_ok    = 1'b1;
                        state_next = reselect ? FIGHT : SEL2;
                    end else begin
                        sel_fail = 1'b1;
                    end
                end
            end
            SEL2: begin
                if (key_valid && hit2) begin
                    if (hp[s2_ix] != '0) begin
                        sel2_ok    = 1'b1;
                        state_next = FIGHT;
                    end else begin
                        sel_fail = 1'b1;
                    end
                end
            end
            FIGHT: begin
                if (key_valid && key_code == K_ATTACK) begin
                    attack = 1'b1;
                    if (hp_new == '0) begin
                        if (others_alive) state_next = turn ? SEL1 : SEL2;
                        else              state_next = OVER;
                    end
                end
            end
            OVER: begin
                if (key_valid && key_code == K_GEN) begin
                    gen_start  = 1'b1;
                    state_next = GEN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2 * PETS; i++) begin
                hp[i]  <= '0;
                def[i] <= '0;
                atk[i] <= '0;
            end
            p1_sel   <= '0;
            p2_sel   <= '0;
            turn     <= 1'b0;
            sel_err  <= 1'b0;
            winner   <= 2'b00;
            g        <= '0;
            reselect <= 1'b0;
        end else begin
            sel_err <= sel_fail;
            if (gen_start) begin
                g        <= '0;
                winner   <= 2'b00;
                turn     <= 1'b0;
                reselect <= 1'b0;
            end
            if (gen_wr) begin
                hp[g]  <= clamp1(rand_in[STAT_W-1:0]);
                def[g] <= clamp1(rand_in[2*STAT_W-1:STAT_W]);
                atk[g] <= clamp1(rand_in[3*STAT_W-1:2*STAT_W]);
                g      <= g + AW'(1);
            end
            if (sel1_ok) begin
                p1_sel   <= k1_idx;
                reselect <= 1'b0;
            end
            if (sel2_ok) begin
                p2_sel   <= k2_idx;
                reselect <= 1'b0;
            end
            if (attack) begin
                hp[d_ix] <= hp_new;
                turn     <= ~turn;
                if (hp_new == '0) begin
                    if (others_alive) reselect <= 1'b1;
                    else              winner   <= turn ? 2'b10 : 2'b01;
                end
            end
        end
    end

    assign state     = state_q;
    assign game_over = (state_q == OVER);

endmodule
